// File: rtl/program_loader.sv
// program_loader
//   Encodes symbolic accumulator-ISA instructions into 9-bit words and writes
//   them to consecutive instruction-memory addresses starting at 0. Every
//   program is closed by the halt word 9'h1FF.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   Start      in   one-cycle pulse, opens a new program at address 0
//   InValid    in   Mnem/Operand valid
//   InReady    out  loader accepts an instruction this cycle (combinational)
//   Mnem       in   5-bit mnemonic (0-13 R-type, 16-21 I-type, 31 halt)
//   Operand    in   register index (R-type) or immediate (I-type)
//   Finish     in   append halt word and close program
//   ImWrEn     out  instruction-memory write strobe (registered)
//   ImAddr     out  write address
//   ImWrData   out  encoded instruction word
//   Busy       out  program open
//   Done       out  program closed with halt word
//   Error      out  load aborted
//   ErrCode    out  1 illegal mnemonic, 2 operand out of range, 3 overflow
//   WordCount  out  words written in the current program, halt included
module program_loader #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    Mnem,
  input  logic [4:0]    Operand,
  input  logic          Finish,
  output logic          ImWrEn,
  output logic [AW-1:0] ImAddr,
  output logic [8:0]    ImWrData,
  output logic          Busy,
  output logic          Done,
  output logic          Error,
  output logic [1:0]    ErrCode,
  output logic [AW:0]   WordCount
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [8:0]    HALT_WORD = 9'h1FF;

  // I-type opcodes 16..21 have Mnem[4] set, so Mnem-16 is simply Mnem[2:0].
  function automatic logic [8:0] f_encode(input logic [4:0] m, input logic [4:0] op);
    if (m[4]) return {1'b1, m[2:0], op};
    else      return {1'b0, m[3:0], op[3:0]};
  endfunction

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_wcnt;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [8:0]    r_wr_data;
  logic [1:0]    r_errcode;

  logic w_accept;
  logic w_halt;
  logic w_rtype;
  logic w_itype;
  logic w_badop;
  logic w_full;

  assign InReady  = (r_state == ST_LOAD) && !Finish && !Start;
  assign w_accept = InValid && InReady;
  // Finish closes the program regardless of InValid; an accepted Mnem 31 does the same.
  assign w_halt   = (r_state == ST_LOAD) && !Start &&
                    (Finish || (w_accept && (Mnem == 5'd31)));
  assign w_rtype  = (Mnem <= 5'd13);
  assign w_itype  = (Mnem >= 5'd16) && (Mnem <= 5'd21);
  assign w_badop  = w_rtype && Operand[4];
  // The last address is kept free for the halt word.
  assign w_full   = (r_addr == LAST_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wcnt    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_errcode <= 2'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (Start) begin
        // A write registered last cycle is already on the outputs and still issues.
        r_state   <= ST_LOAD;
        r_addr    <= '0;
        r_wcnt    <= '0;
        r_errcode <= 2'd0;
      end else if (r_state == ST_LOAD) begin
        if (w_halt) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= HALT_WORD;
          r_wcnt    <= r_wcnt + (AW+1)'(1);
          if (!w_full) r_addr <= r_addr + AW'(1);
          r_state   <= ST_DONE;
        end else if (w_accept) begin
          if (!(w_rtype || w_itype)) begin
            r_state   <= ST_ERR;
            r_errcode <= 2'd1;
          end else if (w_badop) begin
            r_state   <= ST_ERR;
            r_errcode <= 2'd2;
          end else if (w_full) begin
            r_state   <= ST_ERR;
            r_errcode <= 2'd3;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= f_encode(Mnem, Operand);
            r_wcnt    <= r_wcnt + (AW+1)'(1);
            r_addr    <= r_addr + AW'(1);
          end
        end
      end
    end
  end

  assign ImWrEn    = r_wr_en;
  assign ImAddr    = r_wr_addr;
  assign ImWrData  = r_wr_data;
  assign Busy      = (r_state == ST_LOAD);
  assign Done      = (r_state == ST_DONE);
  assign Error     = (r_state == ST_ERR);
  assign ErrCode   = r_errcode;
  assign WordCount = r_wcnt;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic       InValid;
  logic [4:0] Mnem;
  logic [4:0] Operand;
  logic       Finish;

  // dut0: full-size memory; dut1: DEPTH=4 to exercise the capacity limit.
  logic        rdy0, wr0, busy0, done0, err0;
  logic [9:0]  addr0;
  logic [8:0]  data0;
  logic [1:0]  code0;
  logic [10:0] wc0;

  logic        rdy1, wr1, busy1, done1, err1;
  logic [1:0]  addr1;
  logic [8:0]  data1;
  logic [1:0]  code1;
  logic [2:0]  wc1;

  program_loader #(.AW(10), .DEPTH(1024)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InValid(InValid), .InReady(rdy0),
    .Mnem(Mnem), .Operand(Operand), .Finish(Finish), .ImWrEn(wr0), .ImAddr(addr0),
    .ImWrData(data0), .Busy(busy0), .Done(done0), .Error(err0), .ErrCode(code0),
    .WordCount(wc0)
  );

  program_loader #(.AW(2), .DEPTH(4)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InValid(InValid), .InReady(rdy1),
    .Mnem(Mnem), .Operand(Operand), .Finish(Finish), .ImWrEn(wr1), .ImAddr(addr1),
    .ImWrData(data1), .Busy(busy1), .Done(done1), .Error(err1), .ErrCode(code1),
    .WordCount(wc1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 loading, 2 done, 3 error.
  typedef struct { int a; int d; } wr_t;
  wr_t q0[$];
  wr_t q1[$];

  int DEP[2] = '{1024, 4};
  int m_st[2];
  int m_addr[2];
  int m_cnt[2];
  int m_code[2];

  task automatic push_wr(input int k, input int a, input int d);
    wr_t w;
    w.a = a;
    w.d = d;
    if (k == 0) q0.push_back(w);
    else        q1.push_back(w);
    m_cnt[k]++;
  endtask

  task automatic model_step(input int k);
    int m, op;
    bool_dummy: begin end
    m  = int'(Mnem);
    op = int'(Operand);
    if (Start) begin
      m_st[k] = 1; m_addr[k] = 0; m_cnt[k] = 0; m_code[k] = 0;
    end else if (m_st[k] == 1) begin
      if (Finish || (InValid && m == 31)) begin
        push_wr(k, m_addr[k], 511);
        m_st[k] = 2;
      end else if (InValid) begin
        if (!(m <= 13 || (m >= 16 && m <= 21))) begin
          m_st[k] = 3; m_code[k] = 1;
        end else if (m <= 13 && op >= 16) begin
          m_st[k] = 3; m_code[k] = 2;
        end else if (m_addr[k] == DEP[k] - 1) begin
          m_st[k] = 3; m_code[k] = 3;
        end else begin
          if (m <= 13) push_wr(k, m_addr[k], m * 16 + op);
          else         push_wr(k, m_addr[k], 256 + (m - 16) * 32 + op);
          m_addr[k]++;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_code[k] = 0;
    end
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        for (int k = 0; k < 2; k++) begin
          m_st[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_code[k] = 0;
        end
        q0.delete();
        q1.delete();
      end else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check_dut(input int k, input int wr, input int a, input int d,
                           input int busy, input int done, input int err,
                           input int code, input int wc, input int rdy);
    wr_t e;
    int  have;
    have = 0;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
    chk("ImWrEn", k, wr, have);
    if (wr != 0 && have != 0) begin
      chk("ImAddr", k, a, e.a);
      chk("ImWrData", k, d, e.d);
    end
    chk("Busy", k, busy, int'(m_st[k] == 1));
    chk("Done", k, done, int'(m_st[k] == 2));
    chk("Error", k, err, int'(m_st[k] == 3));
    chk("ErrCode", k, code, m_code[k]);
    chk("WordCount", k, wc, m_cnt[k]);
    chk("InReady", k, rdy, int'(m_st[k] == 1 && !Finish && !Start));
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      check_dut(0, int'(wr0), int'(addr0), int'(data0), int'(busy0), int'(done0),
                int'(err0), int'(code0), int'(wc0), int'(rdy0));
      check_dut(1, int'(wr1), int'(addr1), int'(data1), int'(busy1), int'(done1),
                int'(err1), int'(code1), int'(wc1), int'(rdy1));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after the rising edge and are held for one cycle.
  task automatic step(input logic s, input logic v, input logic [4:0] m,
                      input logic [4:0] op, input logic f);
    Start = s; InValid = v; Mnem = m; Operand = op; Finish = f;
    @(posedge Clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic check_all_zero();
    chk("rst_ImWrEn", 0, int'(wr0), 0);
    chk("rst_ImAddr", 0, int'(addr0), 0);
    chk("rst_ImWrData", 0, int'(data0), 0);
    chk("rst_Busy", 0, int'(busy0), 0);
    chk("rst_WordCount", 0, int'(wc0), 0);
    chk("rst_InReady", 0, int'(rdy0), 0);
    chk("rst_ImWrEn", 1, int'(wr1), 0);
    chk("rst_Busy", 1, int'(busy1), 0);
  endtask

  task automatic reset_pulse();
    Start = 0; InValid = 0; Mnem = 0; Operand = 0; Finish = 0;
    Reset_n = 1'b0;
    #1;
    check_all_zero();
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    Start = 0; InValid = 0; Mnem = 0; Operand = 0; Finish = 0;
    repeat (2) @(posedge Clk);
    #2;
    check_all_zero();
    Reset_n = 1'b1;
    idle(1);

    // ADD r3, ADDI 5, Finish -> 003@0, 125@1, 1FF@2
    step(1, 0, 5'd0, 5'd0, 0);
    step(0, 1, 5'd0, 5'd3, 0);
    step(0, 1, 5'd17, 5'd5, 0);
    step(0, 0, 5'd0, 5'd0, 1);
    idle(2);
    chk("prog1_Done", 0, int'(done0), 1);
    chk("prog1_WordCount", 0, int'(wc0), 3);

    // Back-to-back LUT 7, BTRU r2
    step(1, 0, 5'd0, 5'd0, 0);
    step(0, 1, 5'd16, 5'd7, 0);
    step(0, 1, 5'd11, 5'd2, 0);
    step(0, 0, 5'd0, 5'd0, 1);
    idle(1);

    // Illegal mnemonic, then restart
    step(1, 0, 5'd0, 5'd0, 0);
    step(0, 1, 5'd14, 5'd0, 0);
    idle(2);
    chk("illegal_Error", 0, int'(err0), 1);
    chk("illegal_ErrCode", 0, int'(code0), 1);
    step(1, 0, 5'd0, 5'd0, 0);
    step(0, 1, 5'd0, 5'd1, 0);
    step(0, 0, 5'd0, 5'd0, 1);
    idle(1);

    // Operand range: ADD r16 errors, LSRI 31 is legal
    step(1, 0, 5'd0, 5'd0, 0);
    step(0, 1, 5'd0, 5'd16, 0);
    idle(1);
    chk("badop_ErrCode", 0, int'(code0), 2);
    step(1, 0, 5'd0, 5'd0, 0);
    step(0, 1, 5'd21, 5'd31, 0);
    step(0, 1, 5'd31, 5'd0, 0);
    idle(1);

    // Capacity on the DEPTH=4 instance
    step(1, 0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 5'd0, 5'(i), 0);
    idle(1);
    chk("cap_ErrCode", 1, int'(code1), 3);
    step(1, 0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 5'(i + 4), 0);
    step(0, 0, 5'd0, 5'd0, 1);
    idle(1);
    chk("cap_Done", 1, int'(done1), 1);
    chk("cap_WordCount", 1, int'(wc1), 4);

    // Restart mid-program at address 5, then reset with a write pending
    step(1, 0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 5'd4, 5'(i), 0);
    step(1, 1, 5'd0, 5'd0, 0);
    step(0, 1, 5'd7, 5'd9, 0);
    step(0, 1, 5'd2, 5'd1, 0);
    reset_pulse();
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       s, v, f;
      logic [4:0] m, op;
      int         pick;
      if ($urandom_range(0, 599) == 0) begin
        reset_pulse();
      end else begin
        s    = ($urandom_range(0, 39) == 0);
        v    = ($urandom_range(0, 9) < 7);
        f    = ($urandom_range(0, 29) == 0);
        pick = int'($urandom_range(0, 19));
        if (pick < 12)      m = 5'($urandom_range(0, 13));
        else if (pick < 17) m = 5'($urandom_range(16, 21));
        else if (pick < 18) m = 5'd31;
        else begin
          m = 5'($urandom_range(22, 30));
          if ($urandom_range(0, 1) == 0) m = 5'($urandom_range(14, 15));
        end
        if ($urandom_range(0, 4) != 0) op = 5'($urandom_range(0, 15));
        else                           op = 5'($urandom_range(16, 31));
        step(s, v, m, op, f);
      end
    end

    idle(3);
    chk("q_drained", 0, q0.size(), 0);
    chk("q_drained", 1, q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
